k10_lsu: RTL



---
 rtl/k10_lsu_if.sv | 55 +++++
 rtl/k10_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k10_lsu_if.sv
// Signal bundle between the K10 load/store unit, the EX stage, the PMP checker and the data bus.
// The slave view belongs to the LSU; the master view belongs to whatever drives it.
interface k10_lsu_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;

    logic [31:0] o_pmp_addr;
    logic        o_pmp_read;
    logic        o_pmp_write;
    logic        i_pmp_allowed;

    logic        o_bus_req;
    logic        i_bus_gnt;
    logic [31:0] o_bus_addr;
    logic        o_bus_we;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;

    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_exc;
    logic [3:0]  o_rsp_cause;
    logic [31:0] o_rsp_tval;
    logic        o_busy;

    modport slave (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        input  i_pmp_allowed,
        input  i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err,
        output o_req_ready,
        output o_pmp_addr, o_pmp_read, o_pmp_write,
        output o_bus_req, o_bus_addr, o_bus_we, o_bus_be, o_bus_wdata,
        output o_rsp_valid, o_rsp_rdata, o_rsp_exc, o_rsp_cause, o_rsp_tval,
        output o_busy
    );

    modport master (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        output i_pmp_allowed,
        output i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err,
        input  o_req_ready,
        input  o_pmp_addr, o_pmp_read, o_pmp_write,
        input  o_bus_req, o_bus_addr, o_bus_we, o_bus_be, o_bus_wdata,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_exc, o_rsp_cause, o_rsp_tval,
        input  o_busy
    );
endinterface

// File: rtl/k10_lsu.sv
// K10 load/store unit: one request at a time, alignment + PMP check, single data-bus access,
// sign/zero-extended load return and lane-replicated store data.
module k10_lsu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    k10_lsu_if.slave    lsu
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FAULT = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    state_t      state_r;
    state_t      state_next_s;

    logic        we_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  cause_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        fault_s;

    // Size 3 is treated exactly like a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            2'd0:    wd = {4{wdata[7:0]}};
            2'd1:    wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'd0: begin
                if (uns) begin
                    res = {24'd0, sh[7:0]};
                end else begin
                    res = {{24{sh[7]}}, sh[7:0]};
                end
            end
            2'd1: begin
                if (uns) begin
                    res = {16'd0, sh[15:0]};
                end else begin
                    res = {{16{sh[15]}}, sh[15:0]};
                end
            end
            default: res = sh;
        endcase
        return res;
    endfunction

    assign accept_s     = lsu.i_req_valid & (state_r == ST_IDLE);
    assign misaligned_s = is_misaligned(lsu.i_req_size, lsu.i_req_addr[1:0]);
    assign fault_s      = misaligned_s | ~lsu.i_pmp_allowed;

    // The PMP is queried straight from the request lines, so its verdict is ready in the accept cycle.
    assign lsu.o_pmp_addr  = lsu.i_req_addr;
    assign lsu.o_pmp_read  = lsu.i_req_valid & ~lsu.i_req_we;
    assign lsu.o_pmp_write = lsu.i_req_valid &  lsu.i_req_we;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; misalignment outranks a PMP denial, and neither ever reaches the bus.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (fault_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FAULT: state_next_s = ST_IDLE;
            ST_REQ: begin
                if (lsu.i_bus_gnt) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (lsu.i_bus_rvalid) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request capture at accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_r       <= 1'b0;
            size_r     <= 2'd0;
            unsigned_r <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            cause_r    <= 4'd0;
        end else if (accept_s) begin
            we_r       <= lsu.i_req_we;
            size_r     <= lsu.i_req_size;
            unsigned_r <= lsu.i_req_unsigned;
            addr_r     <= lsu.i_req_addr;
            wdata_r    <= lsu.i_req_wdata;
            if (misaligned_s) begin
                cause_r <= lsu.i_req_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            end else begin
                cause_r <= lsu.i_req_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end
        end
    end

    // Bus response capture; the error flag is cleared on every accept so a stale one cannot leak.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else if ((state_r == ST_WAIT) && lsu.i_bus_rvalid) begin
            rdata_r <= lsu.i_bus_rdata;
            err_r   <= lsu.i_bus_err;
        end else if (accept_s) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end
    end

    // Outputs decode from registered state and captured fields only.
    always_comb begin
        lsu.o_req_ready = 1'b0;
        lsu.o_bus_req   = 1'b0;
        lsu.o_bus_addr  = 32'd0;
        lsu.o_bus_we    = 1'b0;
        lsu.o_bus_be    = 4'd0;
        lsu.o_bus_wdata = 32'd0;
        lsu.o_rsp_valid = 1'b0;
        lsu.o_rsp_rdata = 32'd0;
        lsu.o_rsp_exc   = 1'b0;
        lsu.o_rsp_cause = 4'd0;
        lsu.o_rsp_tval  = 32'd0;
        lsu.o_busy      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                lsu.o_req_ready = 1'b1;
                lsu.o_busy      = 1'b0;
            end
            ST_FAULT: begin
                lsu.o_rsp_valid = 1'b1;
                lsu.o_rsp_exc   = 1'b1;
                lsu.o_rsp_cause = cause_r;
                lsu.o_rsp_tval  = addr_r;
            end
            ST_REQ: begin
                lsu.o_bus_req   = 1'b1;
                lsu.o_bus_addr  = {addr_r[31:2], 2'b00};
                lsu.o_bus_we    = we_r;
                lsu.o_bus_be    = calc_be(size_r, addr_r[1:0]);
                lsu.o_bus_wdata = lane_wdata(size_r, wdata_r);
            end
            ST_WAIT: begin
                lsu.o_busy = 1'b1;
            end
            ST_RESP: begin
                lsu.o_rsp_valid = 1'b1;
                if (err_r) begin
                    lsu.o_rsp_exc   = 1'b1;
                    lsu.o_rsp_cause = we_r ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    lsu.o_rsp_tval  = addr_r;
                end else if (!we_r) begin
                    lsu.o_rsp_rdata = load_extract(size_r, unsigned_r, addr_r[1:0], rdata_r);
                end else begin
                    lsu.o_rsp_rdata = 32'd0;
                end
            end
            default: begin
                lsu.o_req_ready = 1'b0;
                lsu.o_busy      = 1'b0;
            end
        endcase
    end

endmodule
